// File: rtl/pdm_pcm_fifo.sv
// rtl/pdm_pcm_fifo.sv - PCM sample FIFO between CIC decimator and register interface
// Single or packed-pair pops, level irq against a threshold, sticky overrun on dropped samples.
module pdm_pcm_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   in_pcm,
   input  logic          in_valid,
   input  logic          flush,
   input  logic          pack,
   input  logic          pop,
   input  logic [CW-1:0] thresh,
   input  logic          ovr_clr,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          overrun,
   output logic          irq
);

   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [15:0]   head0;
   logic [15:0]   head1;
   logic          pop_acc;
   logic          push_acc;
   logic          drop;
   logic [CW-1:0] pop_amt;
   logic [CW-1:0] post_pop;
   logic [CW-1:0] count_nxt;
   logic [AW-1:0] rd_step;

   always_comb begin
      head0    = mem[rd_ptr];
      head1    = mem[rd_ptr + AW'(1)];
      rd_valid = pack ? (count >= CW'(2)) : (count != '0);
      rd_data  = '0;
      if (rd_valid)
         rd_data = pack ? {head1, head0} : {{16{head0[15]}}, head0};
   end

   // The pop is resolved first so a full FIFO being drained can still take a new sample.
   always_comb begin
      pop_acc   = pop && rd_valid;
      pop_amt   = pop_acc ? (pack ? CW'(2) : CW'(1)) : '0;
      rd_step   = pack ? AW'(2) : AW'(1);
      post_pop  = count - pop_amt;
      push_acc  = in_valid && (post_pop < FULL_C);
      drop      = in_valid && !push_acc;
      count_nxt = flush ? '0 : (post_pop + CW'(push_acc));
   end

   assign empty = (count == '0);
   assign full  = (count == FULL_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         irq     <= 1'b0;
      end else begin
         count <= count_nxt;
         irq   <= (thresh != '0) && (count_nxt >= thresh);
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
         end else begin
            if (pop_acc)
               rd_ptr <= rd_ptr + rd_step;
            if (push_acc)
               wr_ptr <= wr_ptr + AW'(1);
            if (drop)
               overrun <= 1'b1;
            else if (ovr_clr)
               overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push_acc)
         mem[wr_ptr] <= in_pcm;
   end

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// tb/tb_pdm_pcm_fifo.sv - directed bench for pdm_pcm_fifo
// Table of single-cycle vectors followed by hand-written full/overrun, flush, wrap and reset sequences.
module tb_pdm_pcm_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_pcm;
   logic        in_valid;
   logic        flush;
   logic        pack;
   logic        pop;
   logic [3:0]  thresh;
   logic        ovr_clr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [3:0]  count;
   logic        empty;
   logic        full;
   logic        overrun;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   pdm_pcm_fifo #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_pcm(in_pcm), .in_valid(in_valid), .flush(flush),
      .pack(pack), .pop(pop), .thresh(thresh), .ovr_clr(ovr_clr), .rd_data(rd_data),
      .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
      .overrun(overrun), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] pcm;
      logic        pp;
      logic        pk;
      logic        fl;
      logic        oc;
      logic [3:0]  th;
      int          ec;
      logic        erv;
      logic [31:0] ed;
      logic        eovr;
      logic        eirq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic [15:0] pcm, logic pp, logic pk, logic fl,
                               logic oc, logic [3:0] th, int ec, logic erv,
                               logic [31:0] ed, logic eovr, logic eirq);
      vec_t v;
      v.iv = iv; v.pcm = pcm; v.pp = pp; v.pk = pk; v.fl = fl; v.oc = oc; v.th = th;
      v.ec = ec; v.erv = erv; v.ed = ed; v.eovr = eovr; v.eirq = eirq;
      return v;
   endfunction

   function automatic logic [15:0] sv(int i);
      return 16'(i * 4951 + 32769);
   endfunction

   function automatic logic [31:0] sext(logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_state(string tag, int ec, logic erv, logic [31:0] ed, logic eovr,
                            logic eirq);
      chk({tag, ".count"}, 32'(count), 32'(ec));
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(erv));
      chk({tag, ".rd_data"}, rd_data, ed);
      chk({tag, ".overrun"}, 32'(overrun), 32'(eovr));
      chk({tag, ".irq"}, 32'(irq), 32'(eirq));
      chk({tag, ".empty"}, 32'(empty), 32'(ec == 0));
      chk({tag, ".full"}, 32'(full), 32'(ec == 8));
   endtask

   // Strobes last exactly one cycle; outputs are checked 2 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      pop      = 1'b0;
      flush    = 1'b0;
      ovr_clr  = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; in_pcm = '0; in_valid = 1'b0; flush = 1'b0; pack = 1'b0;
      pop = 1'b0; thresh = '0; ovr_clr = 1'b0;
      tick();
      tick();
      chk_state("reset", 0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;

      //          iv  pcm       pp pk fl oc th  ec rv  data          ovr irq
      vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 0, 0, 1, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 0, 2, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(1, 16'h7FFF, 0, 0, 0, 0, 0, 3, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 2, 1, 32'hFFFF8000, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 32'h00007FFF, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 16'h1111, 0, 1, 0, 0, 0, 1, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 0, 1, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 16'h2222, 0, 1, 0, 0, 0, 2, 1, 32'h22221111, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 16'hC333, 0, 1, 0, 0, 0, 1, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFC333, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 0, 4, 1, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 0, 4, 2, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(1, 16'h0003, 0, 0, 0, 0, 4, 3, 1, 32'h00000001, 0, 0));
      vecs.push_back(mk(1, 16'h0004, 0, 0, 0, 0, 4, 4, 1, 32'h00000001, 0, 1));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 4, 3, 1, 32'h00000002, 0, 0));
      vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 0, 0, 4, 1, 32'h00000002, 0, 0));
      vecs.push_back(mk(1, 16'h0006, 0, 0, 0, 0, 9, 5, 1, 32'h00000002, 0, 0));
      vecs.push_back(mk(1, 16'h0007, 1, 0, 1, 0, 0, 0, 0, 32'h00000000, 0, 0));

      foreach (vecs[i]) begin
         in_valid = vecs[i].iv; in_pcm = vecs[i].pcm; pop = vecs[i].pp; pack = vecs[i].pk;
         flush = vecs[i].fl; ovr_clr = vecs[i].oc; thresh = vecs[i].th;
         tick();
         chk_state($sformatf("vec%0d", i), vecs[i].ec, vecs[i].erv, vecs[i].ed,
                   vecs[i].eovr, vecs[i].eirq);
      end

      // Fill to full, drop a ninth, overrun set-wins over ovr_clr, then pop+push at full.
      pack = 1'b0; thresh = '0;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_pcm = sv(100 + i);
         tick();
         chk_state($sformatf("fill%0d", i), i, 1'b1, sext(sv(101)), 1'b0, 1'b0);
      end
      in_valid = 1'b1; in_pcm = 16'hDEAD;
      tick();
      chk_state("drop9", 8, 1'b1, sext(sv(101)), 1'b1, 1'b0);
      in_valid = 1'b1; in_pcm = 16'hBEEF; ovr_clr = 1'b1;
      tick();
      chk_state("clr_vs_drop", 8, 1'b1, sext(sv(101)), 1'b1, 1'b0);
      ovr_clr = 1'b1;
      tick();
      chk_state("clr", 8, 1'b1, sext(sv(101)), 1'b0, 1'b0);
      pop = 1'b1; in_valid = 1'b1; in_pcm = 16'h0A0A;
      tick();
      chk_state("full_popush", 8, 1'b1, sext(sv(102)), 1'b0, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         chk($sformatf("drain%0d", k), rd_data, sext(sv(100 + k)));
         pop = 1'b1;
         tick();
      end
      chk_state("drain_tail", 1, 1'b1, 32'h00000A0A, 1'b0, 1'b0);
      pop = 1'b1;
      tick();
      chk_state("drained", 0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Flush with count=5 and overrun set, sample on the same cycle discarded.
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_pcm = sv(200 + i);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         pop = 1'b1;
         tick();
      end
      chk_state("pre_flush", 5, 1'b1, sext(sv(203)), 1'b1, 1'b0);
      flush = 1'b1; in_valid = 1'b1; in_pcm = 16'h5555;
      tick();
      chk_state("flush", 0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk_state("flush_idle", 0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Continuous push+pop with three held entries; pointers wrap several times.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pcm = sv(i);
         tick();
      end
      for (int i = 3; i < 23; i++) begin
         chk($sformatf("wrap_head%0d", i), rd_data, sext(sv(i - 3)));
         in_valid = 1'b1; in_pcm = sv(i); pop = 1'b1;
         tick();
         chk($sformatf("wrap_count%0d", i), 32'(count), 32'd3);
      end
      for (int i = 20; i < 23; i++) begin
         chk($sformatf("wrap_tail%0d", i), rd_data, sext(sv(i)));
         pop = 1'b1;
         tick();
      end
      chk_state("wrap_done", 0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset mid-stream with a strobe present and overrun and irq set.
      thresh = 4'd2;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_pcm = sv(300 + i);
         tick();
      end
      chk_state("pre_rst", 8, 1'b1, sext(sv(300)), 1'b1, 1'b1);
      rst = 1'b1; in_valid = 1'b1; in_pcm = 16'h1234;
      tick();
      chk_state("mid_rst", 0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0; thresh = '0;
      tick();
      chk_state("post_rst", 0, 1'b0, 32'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
